uart_rx_cfg: RTL and testbench

Parametrised UART receiver for the host-to-FPGA image link. It replaces the fixed 8N1 receiver with a configurable data width, optional parity and one or two stop bits. It takes a 3-sample majority vote at mid-bit, reports parity, framing and break errors, and re-arms at mid-stop-bit so back-to-back frames tolerate clock mismatch. It sits between the RX pin and the pixel/command byte assembler.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync_vote.sv | 35 +++
 rtl/uart_rx_cfg.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Parity modes, FSM encoding and the expected-parity function.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT
  } state_e;

  function automatic logic exp_parity(
    input logic [8:0] d,
    input int         w,
    input int         mode
  );
    logic x;
    x = 1'b0;
    for (int i = 0; i < 9; i++)
      if (i < w) x = x ^ d[i];
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop RX synchroniser plus 3-sample mid-bit majority vote.
// The third sample is the live synchronised bit at c = MID+1.
module uart_rx_sync_vote #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] mid_i,
  output logic          rx_data_o,
  output logic          vote_o
);

  logic s1_q, s2_q;
  logic v0_q, v1_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      v0_q <= 1'b1;
      v1_q <= 1'b1;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
      if (cnt_i == mid_i - 1'b1) v0_q <= s2_q;
      if (cnt_i == mid_i)        v1_q <= s2_q;
    end
  end

  assign rx_data_o = s2_q;
  assign vote_o    = (v0_q & v1_q) | (v0_q & s2_q) | (v1_q & s2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity,
// 1 or 2 stop bits, majority-voted sampling and error reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int MI = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] MID  = CW'(MI);
  localparam logic [CW-1:0] MID1 = CW'(MI + 1);
  localparam logic [CW-1:0] MID2 = CW'(MI + 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDXL = IW'(DATA_BITS - 1);
  localparam logic          STPL = 1'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 ones_q, ones_d;
  logic                 ferr_q, ferr_d;
  logic                 stopv_q, stopv_d;
  logic                 stpn_q, stpn_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 frm_q, frm_d;
  logic                 brk_q, brk_d;

  logic rx, vote, last;

  uart_rx_sync_vote #(.CW(CW)) u_sv (
    .clk_i     (i_Clock),
    .rst_i     (i_Reset),
    .rx_i      (i_Rx_Serial),
    .cnt_i     (cnt_q),
    .mid_i     (MID),
    .rx_data_o (rx),
    .vote_o    (vote)
  );

  assign last = (stpn_q == STPL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ones_d  = ones_q;
    ferr_d  = ferr_q;
    stopv_d = stopv_q;
    stpn_d  = stpn_q;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    perr_d  = perr_q;
    frm_d   = frm_q;
    brk_d   = brk_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          state_d = ST_START;
          idx_d   = '0;
          ones_d  = 1'b0;
          ferr_d  = 1'b0;
          stpn_d  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == MID1 && vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q == MID1) begin
          sh_d   = {vote, sh_q[DATA_BITS-1:1]};
          ones_d = ones_q | vote;
        end
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (idx_q == IDXL)
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else
            idx_d = idx_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt_q == MID1) begin
          par_d  = vote;
          ones_d = ones_q | vote;
        end
        if (cnt_q == LAST) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end
      end
      ST_STOP: begin
        if (cnt_q == MID1) begin
          ones_d = ones_q | vote;
          ferr_d = ferr_q | ~vote;
          if (last) begin
            dv_d    = 1'b1;
            byte_d  = sh_q;
            stopv_d = vote;
            frm_d   = ferr_q | ~vote;
            brk_d   = ~(ones_q | vote);
            perr_d  = (PARITY != PAR_NONE) &&
                      (par_q != exp_parity(9'(sh_q), DATA_BITS, PARITY));
          end
        end
        // Leave one cycle after the pulse so a new edge is seen in time
        if (last && cnt_q == MID2) begin
          state_d = stopv_q ? ST_IDLE : ST_WAIT;
          cnt_d   = '0;
        end else if (!last && cnt_q == LAST) begin
          stpn_d = 1'b1;
          cnt_d  = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = '0;
        if (rx) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ones_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stopv_q <= 1'b1;
      stpn_q  <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      perr_q  <= 1'b0;
      frm_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      ones_q  <= ones_d;
      ferr_q  <= ferr_d;
      stopv_q <= stopv_d;
      stpn_q  <= stpn_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      perr_q  <= perr_d;
      frm_q   <= frm_d;
      brk_q   <= brk_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = frm_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1, 8E1 and 7O2 instances at 16 clocks/bit.
// Expected frames are queued when driven and checked on o_Rx_DV.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct {
    int          k;
    logic [8:0]  d;
    logic        pe;
    logic        fe;
    logic        br;
    logic [63:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rx;
  logic [2:0]  dv, pe, fe, br, busy;
  logic [7:0]  b0, b1;
  logic [6:0]  b2;
  logic [63:0] cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]),
    .o_Rx_DV(dv[0]), .o_Rx_Byte(b0), .o_Parity_Err(pe[0]),
    .o_Frame_Err(fe[0]), .o_Break(br[0]), .o_Busy(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]),
    .o_Rx_DV(dv[1]), .o_Rx_Byte(b1), .o_Parity_Err(pe[1]),
    .o_Frame_Err(fe[1]), .o_Break(br[1]), .o_Busy(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]),
    .o_Rx_DV(dv[2]), .o_Rx_Byte(b2), .o_Parity_Err(pe[2]),
    .o_Frame_Err(fe[2]), .o_Break(br[2]), .o_Busy(busy[2]));

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] byt(input int k);
    case (k)
      0:       return 9'(b0);
      1:       return 9'(b1);
      default: return 9'(b2);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dv lands 3 + (frame bits - 1)*CPB + MID + 2 cycles after the edge
  task automatic push(input int k, input logic [8:0] d,
                      input logic p, input logic f, input logic b,
                      input int nbits);
    exp_t e;
    e.k   = k;
    e.d   = d;
    e.pe  = p;
    e.fe  = f;
    e.br  = b;
    e.cyc = cyc + 64'(3 + (nbits - 1) * CPB + 9);
    sb.push_back(e);
  endtask

  task automatic send(input int k, input logic [8:0] d,
                      input int nb, input int np, input logic pb,
                      input int ns, input int gbit, input int abit);
    logic v;
    for (int b = 0; b < 1 + nb + np + ns; b++) begin
      if (b == 0)                    v = 1'b0;
      else if (b <= nb)              v = d[b-1];
      else if (np != 0 && b == nb+1) v = pb;
      else                           v = 1'b1;
      for (int j = 0; j < CPB; j++) begin
        if (b == abit && j == 8) return;
        rx[k] = (b == gbit && j == 8) ? ~v : v;
        tick();
      end
    end
    rx[k] = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (dv[k] === 1'b1) begin
        if (sb.size() == 0) begin
          check("dv_unexpected", 64'(k), 64'hFF);
        end else begin
          e = sb.pop_front();
          check("dv_inst", 64'(k), 64'(e.k));
          check("dv_cycle", cyc, e.cyc);
          check("byte", 64'(byt(k)), 64'(e.d));
          check("parity_err", 64'(pe[k]), 64'(e.pe));
          check("frame_err", 64'(fe[k]), 64'(e.fe));
          check("break", 64'(br[k]), 64'(e.br));
        end
      end
    end
  end

  initial begin
    logic [63:0] t0;
    rst = 1'b1;
    rx  = 3'b111;
    repeat (3) tick();
    check("rst_dv", 64'(dv), 64'd0);
    check("rst_byte0", 64'(b0), 64'd0);
    check("rst_byte2", 64'(b2), 64'd0);
    check("rst_pe", 64'(pe), 64'd0);
    check("rst_fe", 64'(fe), 64'd0);
    check("rst_br", 64'(br), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (5) tick();

    // 8N1 back-to-back frames
    push(0, 9'h0A5, 0, 0, 0, 10);
    send(0, 9'h0A5, 8, 0, 0, 1, -1, -1);
    push(0, 9'h03C, 0, 0, 0, 10);
    send(0, 9'h03C, 8, 0, 0, 1, -1, -1);
    repeat (20) tick();

    // 8E1 wrong then right parity
    push(1, 9'h003, 1, 0, 0, 11);
    send(1, 9'h003, 8, 1, 1'b1, 1, -1, -1);
    push(1, 9'h003, 0, 0, 0, 11);
    send(1, 9'h003, 8, 1, 1'b0, 1, -1, -1);
    repeat (20) tick();

    // High glitch at mid of data bit 3
    push(0, 9'h000, 0, 0, 0, 10);
    send(0, 9'h000, 8, 0, 0, 1, 4, -1);
    repeat (20) tick();

    // Short start glitch
    t0 = cyc;
    rx[0] = 1'b0;
    repeat (4) tick();
    rx[0] = 1'b1;
    tick();
    check("glitch_busy_hi", 64'(busy[0]), 64'd1);
    while (cyc < t0 + 16) tick();
    check("glitch_busy_lo", 64'(busy[0]), 64'd0);
    repeat (20) tick();
    push(0, 9'h05A, 0, 0, 0, 10);
    send(0, 9'h05A, 8, 0, 0, 1, -1, -1);
    repeat (20) tick();

    // 7O2 break: 12 bit times low
    t0 = cyc;
    push(2, 9'h000, 1, 1, 1, 11);
    rx[2] = 1'b0;
    while (cyc < t0 + 185) tick();
    check("break_wait_busy", 64'(busy[2]), 64'd1);
    while (cyc < t0 + 12 * CPB) tick();
    rx[2] = 1'b1;
    repeat (20) tick();
    check("break_idle_busy", 64'(busy[2]), 64'd0);
    check("break_held", 64'(br[2]), 64'd1);
    push(2, 9'h041, 0, 0, 0, 11);
    send(2, 9'h041, 7, 1, 1'b1, 2, -1, -1);
    repeat (20) tick();

    // Reset during data bit 4
    send(0, 9'h0C3, 8, 0, 0, 1, -1, 5);
    check("pre_rst_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_byte0", 64'(b0), 64'd0);
    check("arst_byte1", 64'(b1), 64'd0);
    check("arst_byte2", 64'(b2), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_br", 64'(br), 64'd0);
    rx[0] = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (40) tick();
    push(0, 9'h0C3, 0, 0, 0, 10);
    send(0, 9'h0C3, 8, 0, 0, 1, -1, -1);
    repeat (40) tick();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
